// File: rtl/uart_pkg.sv
// Shared UART definitions: data width and transmit-sequencer state encoding.
package uart_pkg;

    localparam int UART_DATA_W = 8;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SEND = 2'd1;
    localparam logic [1:0] ST_GAP  = 2'd2;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        SEND = ST_SEND,
        GAP  = ST_GAP
    } txState_t;

endpackage

// File: rtl/sync_fifo.sv
// Generic synchronous FIFO with a registered read port loaded on rdEn.
module sync_fifo #(
    parameter int DEPTH      = 16,
    parameter int ADDR_WIDTH = 4,
    parameter int WIDTH      = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wrEn,
    input  logic [WIDTH-1:0]      wrData,
    input  logic                  rdEn,
    output logic [WIDTH-1:0]      rdData,
    output logic                  full,
    output logic                  empty,
    output logic [ADDR_WIDTH:0]   count
);

    localparam logic [ADDR_WIDTH:0] CAP = (ADDR_WIDTH + 1)'(DEPTH);

    logic [WIDTH-1:0]      mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wrPtr;
    logic [ADDR_WIDTH-1:0] rdPtr;
    logic                  push;
    logic                  pop;

    // A full FIFO refuses writes even when a pop happens on the same edge.
    assign push  = wrEn && !full;
    assign pop   = rdEn && !empty;
    assign full  = (count == CAP);
    assign empty = (count == '0);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wrPtr] <= wrData;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wrPtr  <= '0;
            rdPtr  <= '0;
            count  <= '0;
            rdData <= '0;
        end else begin
            if (push) begin
                wrPtr <= wrPtr + 1'b1;
            end
            if (pop) begin
                rdData <= mem[rdPtr];
                rdPtr  <= rdPtr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_feeder.sv
// Byte queue and frame sequencer feeding the UART transmitter, with an
// idle gap after each frame so the transmitter can rearm.
module uart_tx_feeder
    import uart_pkg::*;
#(
    parameter int DEPTH      = 16,
    parameter int ADDR_WIDTH = 4,
    parameter int GAP_CYCLES = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   wrEn,
    input  logic [UART_DATA_W-1:0] wrData,
    output logic                   full,
    output logic                   empty,
    output logic [ADDR_WIDTH:0]    count,
    output logic                   overflow,
    output logic                   txEnable,
    output logic [UART_DATA_W-1:0] uartInByte,
    input  logic                   uartTxDone,
    output logic                   busy
);

    localparam int GW = $clog2(GAP_CYCLES);
    localparam logic [GW-1:0] GAP_LOAD = GW'(GAP_CYCLES - 1);

    txState_t      state;
    logic [GW-1:0] gapCnt;
    logic          pop;

    // The FIFO read register is the byte presented to the transmitter.
    assign pop = (state == IDLE) && !empty;

    sync_fifo #(
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .WIDTH      (UART_DATA_W)
    ) uFifo (
        .clk    (clk),
        .reset  (reset),
        .wrEn   (wrEn),
        .wrData (wrData),
        .rdEn   (pop),
        .rdData (uartInByte),
        .full   (full),
        .empty  (empty),
        .count  (count)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            txEnable <= 1'b0;
            busy     <= 1'b0;
            gapCnt   <= '0;
            overflow <= 1'b0;
        end else begin
            overflow <= wrEn && full;
            unique case (state)
                IDLE: begin
                    if (!empty) begin
                        state    <= SEND;
                        txEnable <= 1'b1;
                        busy     <= 1'b1;
                    end
                end
                SEND: begin
                    if (uartTxDone) begin
                        state    <= GAP;
                        txEnable <= 1'b0;
                        gapCnt   <= GAP_LOAD;
                    end
                end
                GAP: begin
                    if (gapCnt == '0) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        gapCnt <= gapCnt - 1'b1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    txEnable <= 1'b0;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Bench for uart_tx_feeder: vector table, directed corner sequences and
// randomized traffic against a queue-and-timeline reference model.
module tb_uart_tx_feeder;

    localparam int DEPTH = 16;
    localparam int AW    = 4;
    localparam int GAP   = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        wrEn;
    logic [7:0]  wrData;
    logic        full;
    logic        empty;
    logic [AW:0] count;
    logic        overflow;
    logic        txEnable;
    logic [7:0]  uartInByte;
    logic        uartTxDone;
    logic        busy;

    always #5 clk = ~clk;

    uart_tx_feeder #(
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (AW),
        .GAP_CYCLES (GAP)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .wrEn       (wrEn),
        .wrData     (wrData),
        .full       (full),
        .empty      (empty),
        .count      (count),
        .overflow   (overflow),
        .txEnable   (txEnable),
        .uartInByte (uartInByte),
        .uartTxDone (uartTxDone),
        .busy       (busy)
    );

    int passCnt = 0;
    int totalCnt = 0;

    // reference model: pending bytes, frame in progress, and the edge after
    // which the sequencer is idle again
    logic [7:0] mQ[$];
    bit         mSend = 0;
    logic [7:0] mByte = 8'h00;
    bit         mOvf = 0;
    int         mIdleFrom = 0;
    int         edgeNo = 0;
    int         lastDoneEdge = 0;

    int         txAge = 0;
    bit         prevTx = 0;
    bit         gapCheck = 0;
    logic [7:0] sent[$];
    int         ovfSeen = 0;
    int         peakCount = 0;

    typedef struct {
        bit         w;
        logic [7:0] d;
        bit         dn;
        bit         tx;
        logic [7:0] b;
        int         cnt;
        bit         bz;
    } vec_t;

    vec_t tbl[8];

    task automatic check(input string name, input int act, input int exp);
        totalCnt++;
        if (act == exp) passCnt++;
        else $display("FAIL %s: got %0h expected %0h (edge %0d)",
                      name, act, exp, edgeNo);
    endtask

    task automatic modelEdge(input bit w, input logic [7:0] d,
                             input bit dn, input bit r);
        bit popNow;
        bit wasFull;
        edgeNo++;
        if (r) begin
            mQ.delete();
            mSend = 0;
            mByte = 8'h00;
            mOvf = 0;
            mIdleFrom = edgeNo;
        end else begin
            wasFull = (mQ.size() == DEPTH);
            popNow = !mSend && (edgeNo - 1 >= mIdleFrom) && (mQ.size() > 0);
            mOvf = w && wasFull;
            if (popNow) begin
                mByte = mQ.pop_front();
                mSend = 1;
            end else if (mSend && dn) begin
                mSend = 0;
                mIdleFrom = edgeNo + GAP;
                lastDoneEdge = edgeNo;
            end
            if (w && !wasFull) mQ.push_back(d);
        end
    endtask

    task automatic checkModel();
        check("txEnable", int'(txEnable), int'(mSend));
        check("uartInByte", int'(uartInByte), int'(mByte));
        check("count", int'(count), mQ.size());
        check("full", int'(full), int'(mQ.size() == DEPTH));
        check("empty", int'(empty), int'(mQ.size() == 0));
        check("overflow", int'(overflow), int'(mOvf));
        check("busy", int'(busy), int'(mSend || (edgeNo < mIdleFrom)));
    endtask

    task automatic drive(input bit w, input logic [7:0] d,
                         input bit dn, input bit r);
        wrEn = w;
        wrData = d;
        uartTxDone = dn;
        reset = r;
        @(posedge clk);
        modelEdge(w, d, dn, r);
        if (mSend) txAge++;
        else txAge = 0;
        @(negedge clk);
        checkModel();
        if (overflow) ovfSeen++;
        if (int'(count) > peakCount) peakCount = int'(count);
        if (txEnable && !prevTx) begin
            sent.push_back(uartInByte);
            if (gapCheck && lastDoneEdge > 0)
                check("riseAfterDone", edgeNo - lastDoneEdge, GAP + 1);
        end
        prevTx = txEnable;
    endtask

    task automatic run(input int n, input int wrPct, input int frameLen);
        bit w;
        bit dn;
        for (int i = 0; i < n; i++) begin
            w = ($urandom_range(0, 99) < wrPct);
            if (mSend) dn = (txAge >= frameLen);
            else dn = ($urandom_range(0, 9) == 0);
            drive(w, 8'($urandom), dn, 0);
        end
    endtask

    task automatic drain(input int frameLen);
        int guard;
        guard = 0;
        while ((mQ.size() > 0 || mSend || edgeNo <= mIdleFrom) && guard < 3000) begin
            drive(0, 8'h00, mSend && (txAge >= frameLen), 0);
            guard++;
        end
        if (guard >= 3000) check("drainTimeout", 1, 0);
    endtask

    initial begin
        wrEn = 0;
        wrData = 8'h00;
        uartTxDone = 0;
        reset = 1;

        // 1: reset then idle
        repeat (3) drive(0, 8'h00, 0, 1);
        check("rst_txEnable", int'(txEnable), 0);
        check("rst_empty", int'(empty), 1);
        check("rst_count", int'(count), 0);
        check("rst_busy", int'(busy), 0);
        repeat (100) drive(0, 8'h00, 0, 0);
        check("idle_txEnable", int'(txEnable), 0);
        check("idle_count", int'(count), 0);
        check("idle_byte", int'(uartInByte), 0);

        // 2: single byte, vector table
        tbl[0] = '{1, 8'hA5, 0, 0, 8'h00, 1, 0};
        tbl[1] = '{0, 8'h00, 0, 1, 8'hA5, 0, 1};
        tbl[2] = '{0, 8'h00, 0, 1, 8'hA5, 0, 1};
        tbl[3] = '{0, 8'h00, 1, 0, 8'hA5, 0, 1};
        tbl[4] = '{0, 8'h00, 0, 0, 8'hA5, 0, 1};
        tbl[5] = '{0, 8'h00, 0, 0, 8'hA5, 0, 1};
        tbl[6] = '{0, 8'h00, 0, 0, 8'hA5, 0, 1};
        tbl[7] = '{0, 8'h00, 0, 0, 8'hA5, 0, 0};
        for (int i = 0; i < 8; i++) begin
            drive(tbl[i].w, tbl[i].d, tbl[i].dn, 0);
            check($sformatf("vec%0d_tx", i), int'(txEnable), int'(tbl[i].tx));
            check($sformatf("vec%0d_byte", i), int'(uartInByte), int'(tbl[i].b));
            check($sformatf("vec%0d_count", i), int'(count), tbl[i].cnt);
            check($sformatf("vec%0d_busy", i), int'(busy), int'(tbl[i].bz));
        end

        // 3: burst, order and back-to-back spacing
        sent.delete();
        peakCount = 0;
        lastDoneEdge = 0;
        gapCheck = 1;
        for (int i = 1; i <= 5; i++)
            drive(1, 8'(i), mSend && (txAge >= 6), 0);
        drain(6);
        gapCheck = 0;
        check("burst_frames", sent.size(), 5);
        for (int i = 0; i < sent.size() && i < 5; i++)
            check($sformatf("burst_order%0d", i), int'(sent[i]), i + 1);
        check("burst_peak", peakCount, 4);

        // 4: fill with transmitter stalled, then overflow
        sent.delete();
        ovfSeen = 0;
        for (int i = 0; i < 18; i++) drive(1, 8'(8'h40 + i), 0, 0);
        check("ovf_full", int'(full), 1);
        check("ovf_count", int'(count), DEPTH);
        check("ovf_pulses", ovfSeen, 1);
        drive(0, 8'h00, 0, 0);
        check("ovf_pulse_clear", int'(overflow), 0);
        drain(3);
        check("ovf_frames", sent.size(), 17);
        for (int i = 0; i < sent.size() && i < 17; i++)
            check($sformatf("ovf_order%0d", i), int'(sent[i]), 8'h40 + i);

        // 5: write on the same edge the sequencer pops
        sent.delete();
        for (int i = 0; i < 4; i++) drive(1, 8'(8'h60 + i), 0, 0);
        check("sim_pre_count", int'(count), 3);
        drive(0, 8'h00, 1, 0);
        check("sim_done_tx", int'(txEnable), 0);
        repeat (GAP) drive(0, 8'h00, 0, 0);
        drive(1, 8'h77, 0, 0);
        check("sim_count", int'(count), 3);
        check("sim_tx", int'(txEnable), 1);
        check("sim_byte", int'(uartInByte), 8'h61);
        drain(2);
        check("sim_frames", sent.size(), 5);
        for (int i = 0; i < sent.size() && i < 5; i++)
            check($sformatf("sim_order%0d", i), int'(sent[i]),
                  (i < 4) ? 8'h60 + i : 8'h77);

        // 6: reset during a frame
        for (int i = 0; i < 5; i++) drive(1, 8'(8'h80 + i), 0, 0);
        check("mid_pre_count", int'(count), 4);
        check("mid_pre_tx", int'(txEnable), 1);
        drive(0, 8'h00, 0, 1);
        check("mid_rst_tx", int'(txEnable), 0);
        check("mid_rst_count", int'(count), 0);
        sent.delete();
        drive(1, 8'h3C, 0, 0);
        drain(4);
        check("mid_frames", sent.size(), 1);
        if (sent.size() > 0) check("mid_first", int'(sent[0]), 8'h3C);

        // randomized traffic
        repeat (40) begin
            run(50, $urandom_range(10, 90), $urandom_range(1, 8));
            if ($urandom_range(0, 19) == 0) drive(0, 8'h00, 0, 1);
        end
        drain(3);

        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end

endmodule
